// File: rtl/dcache_rd_resp_if.sv
`default_nettype none
// ============================================================================
// Module      : dcache_rd_resp_if
// Description : Request, cache-array and response signals of dcache_rd_resp.
// Revision    : 1.0 - initial release
// ============================================================================
interface dcache_rd_resp_if;
    logic        req_valid;
    logic [14:0] req_addr;
    logic [1:0]  req_size;
    logic        glb_inv;
    logic        stall;
    logic        cache_req_v;
    logic [12:0] cache_addr;
    logic [31:0] cache_rdata;
    logic        cache_ack;
    logic        rsp_v;
    logic [31:0] rsp_data;

    // master: TLB stage plus cache array; slave: the read responder
    modport master (
        output req_valid, req_addr, req_size, glb_inv, cache_rdata, cache_ack,
        input  stall, cache_req_v, cache_addr, rsp_v, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, req_size, glb_inv, cache_rdata, cache_ack,
        output stall, cache_req_v, cache_addr, rsp_v, rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/dcache_rd_resp.sv
`default_nettype none
// ============================================================================
// Module      : dcache_rd_resp
// Description : Memory-stage read responder: one or two word fetches, little-
//               endian byte assembly. Optional last-word buffer when the
//               macro DCRSP_LASTWORD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_rd_resp (
    input  wire logic       clk,
    input  wire logic       rst,
    dcache_rd_resp_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_W1   = 2'd1,
        S_W2   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic [1:0]  r_off;
    logic [1:0]  r_size;
    logic [31:0] r_lo;
    logic [12:0] r_cache_addr;
    logic [31:0] r_rsp_data;

    logic        w_spill;
    logic        w_lw_hit;
    logic [31:0] w_lw_data;

    // Shift the two-word window down to the start byte, keep size+1 bytes
    function automatic logic [31:0] f_assemble(input logic [63:0] pair,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size);
        logic [63:0] sh;
        logic [31:0] mask;
        sh   = pair >> {off, 3'b000};
        mask = 32'hFFFF_FFFF >> {~size, 3'b000};
        return sh[31:0] & mask;
    endfunction

    assign w_spill = ({1'b0, r_off} + {1'b0, r_size}) > 3'd3;

`ifdef DCRSP_LASTWORD_EN
    logic        r_lw_valid;
    logic [12:0] r_lw_idx;
    logic [31:0] r_lw_data;
    logic        w_req_spill;
    logic        w_ack_take;

    assign w_req_spill = ({1'b0, bus.req_addr[1:0]} + {1'b0, bus.req_size}) > 3'd3;
    assign w_lw_hit    = r_lw_valid && !w_req_spill && (r_lw_idx == bus.req_addr[14:2]);
    assign w_lw_data   = r_lw_data;
    assign w_ack_take  = bus.cache_ack && ((r_state == S_W1) || (r_state == S_W2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lw_valid <= 1'b0;
            r_lw_idx   <= 13'd0;
            r_lw_data  <= 32'd0;
        end else if (bus.glb_inv) begin
            r_lw_valid <= 1'b0;
        end else if (w_ack_take) begin
            r_lw_valid <= 1'b1;
            r_lw_idx   <= r_cache_addr;
            r_lw_data  <= bus.cache_rdata;
        end
    end
`else
    assign w_lw_hit  = 1'b0;
    assign w_lw_data = 32'd0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_off        <= 2'd0;
            r_size       <= 2'd0;
            r_lo         <= 32'd0;
            r_cache_addr <= 13'd0;
            r_rsp_data   <= 32'd0;
        end else if (bus.glb_inv) begin
            r_state <= S_IDLE;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_off  <= bus.req_addr[1:0];
                        r_size <= bus.req_size;
                        if (w_lw_hit) begin
                            r_rsp_data <= f_assemble({32'd0, w_lw_data},
                                                     bus.req_addr[1:0], bus.req_size);
                            r_state    <= S_DONE;
                        end else begin
                            r_cache_addr <= bus.req_addr[14:2];
                            r_state      <= S_W1;
                        end
                    end
                end
                S_W1: begin
                    if (bus.cache_ack) begin
                        r_lo <= bus.cache_rdata;
                        if (w_spill) begin
                            // 13-bit add wraps the top word back to zero
                            r_cache_addr <= r_cache_addr + 13'd1;
                            r_state      <= S_W2;
                        end else begin
                            r_rsp_data <= f_assemble({32'd0, bus.cache_rdata}, r_off, r_size);
                            r_state    <= S_DONE;
                        end
                    end
                end
                S_W2: begin
                    if (bus.cache_ack) begin
                        r_rsp_data <= f_assemble({bus.cache_rdata, r_lo}, r_off, r_size);
                        r_state    <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.stall       = (r_state != S_IDLE);
    assign bus.cache_req_v = (r_state == S_W1) || (r_state == S_W2);
    assign bus.cache_addr  = r_cache_addr;
    assign bus.rsp_v       = (r_state == S_DONE) && !bus.glb_inv;
    assign bus.rsp_data    = r_rsp_data;
endmodule
`default_nettype wire
